// File: rtl/sap_pkg.sv
// Shared definitions for the SAP-1 controller: opcodes, T-state encoding,
// and control-word bit positions.
package sap_pkg;

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_LDA = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_STA = 4'b0100;
  localparam logic [3:0] OP_LDI = 4'b0101;
  localparam logic [3:0] OP_JMP = 4'b0110;
  localparam logic [3:0] OP_JC  = 4'b0111;
  localparam logic [3:0] OP_JZ  = 4'b1000;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4
  } tstate_t;

  // Control-word bit positions, MSB first: hlt mi ri ro io ii ai ao eo su bi oi ce co j fi
  localparam int CW_HLT = 15;
  localparam int CW_MI  = 14;
  localparam int CW_RI  = 13;
  localparam int CW_RO  = 12;
  localparam int CW_IO  = 11;
  localparam int CW_II  = 10;
  localparam int CW_AI  = 9;
  localparam int CW_AO  = 8;
  localparam int CW_EO  = 7;
  localparam int CW_SU  = 6;
  localparam int CW_BI  = 5;
  localparam int CW_OI  = 4;
  localparam int CW_CE  = 3;
  localparam int CW_CO  = 2;
  localparam int CW_J   = 1;
  localparam int CW_FI  = 0;

  typedef logic [15:0] ctrl_word_t;

endpackage

// File: rtl/sap_tstate_counter.sv
// T-state sequencer: counts T0..T4 and wraps; freezes while hold is high.
import sap_pkg::*;

module sap_tstate_counter (
  input  logic    clk,
  input  logic    reset,
  input  logic    hold,
  output tstate_t tstate
);

  tstate_t state_reg;
  tstate_t state_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= T0;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (!hold) begin
      case (state_reg)
        T0:      state_next = T1;
        T1:      state_next = T2;
        T2:      state_next = T3;
        T3:      state_next = T4;
        default: state_next = T0;
      endcase
    end
  end

  assign tstate = state_reg;

endmodule

// File: rtl/sap_controller.sv
// SAP-1 microcode controller: decodes T-state, opcode and flags into control lines.
// Define SAP_COND_JUMP_EN to enable the JC/JZ conditional jumps.
import sap_pkg::*;

module sap_controller #(
  parameter int OPCODE_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                carry_flag,
  input  logic                zero_flag,
  output logic                hlt,
  output logic                mi,
  output logic                ri,
  output logic                ro,
  output logic                io,
  output logic                ii,
  output logic                ai,
  output logic                ao,
  output logic                eo,
  output logic                su,
  output logic                bi,
  output logic                oi,
  output logic                ce,
  output logic                co,
  output logic                j,
  output logic                fi,
  output logic [2:0]          tstate
);

  tstate_t    ts;
  logic       halted_reg;
  logic       halted_next;
  ctrl_word_t cw;

`ifndef SAP_COND_JUMP_EN
  logic unused_flags;
  assign unused_flags = carry_flag ^ zero_flag;
`endif

  sap_tstate_counter u_tstate (
    .clk    (clk),
    .reset  (reset),
    .hold   (halted_reg),
    .tstate (ts)
  );

  // The counter steps T2->T3 on the same edge that latches halted, so it freezes at 3.
  assign halted_next = halted_reg | ((ts == T2) && (opcode == OP_HLT));

  always_ff @(posedge clk) begin
    if (reset) begin
      halted_reg <= 1'b0;
    end else begin
      halted_reg <= halted_next;
    end
  end

  always_comb begin
    cw = '0;
    if (halted_reg) begin
      cw[CW_HLT] = 1'b1;
    end else begin
      case (ts)
        T0: begin
          cw[CW_CO] = 1'b1;
          cw[CW_MI] = 1'b1;
        end
        T1: begin
          cw[CW_RO] = 1'b1;
          cw[CW_II] = 1'b1;
          cw[CW_CE] = 1'b1;
        end
        T2: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              cw[CW_IO] = 1'b1;
              cw[CW_MI] = 1'b1;
            end
            OP_LDI: begin
              cw[CW_IO] = 1'b1;
              cw[CW_AI] = 1'b1;
            end
            OP_JMP: begin
              cw[CW_IO] = 1'b1;
              cw[CW_J]  = 1'b1;
            end
`ifdef SAP_COND_JUMP_EN
            OP_JC: begin
              cw[CW_IO] = carry_flag;
              cw[CW_J]  = carry_flag;
            end
            OP_JZ: begin
              cw[CW_IO] = zero_flag;
              cw[CW_J]  = zero_flag;
            end
`endif
            OP_OUT: begin
              cw[CW_AO] = 1'b1;
              cw[CW_OI] = 1'b1;
            end
            OP_HLT: cw[CW_HLT] = 1'b1;
            default: cw = '0;
          endcase
        end
        T3: begin
          case (opcode)
            OP_LDA: begin
              cw[CW_RO] = 1'b1;
              cw[CW_AI] = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              cw[CW_RO] = 1'b1;
              cw[CW_BI] = 1'b1;
            end
            OP_STA: begin
              cw[CW_AO] = 1'b1;
              cw[CW_RI] = 1'b1;
            end
            default: cw = '0;
          endcase
        end
        T4: begin
          if (opcode == OP_ADD || opcode == OP_SUB) begin
            cw[CW_EO] = 1'b1;
            cw[CW_AI] = 1'b1;
            cw[CW_FI] = 1'b1;
            cw[CW_SU] = (opcode == OP_SUB);
          end
        end
        default: cw = '0;
      endcase
    end
  end

  assign hlt    = cw[CW_HLT];
  assign mi     = cw[CW_MI];
  assign ri     = cw[CW_RI];
  assign ro     = cw[CW_RO];
  assign io     = cw[CW_IO];
  assign ii     = cw[CW_II];
  assign ai     = cw[CW_AI];
  assign ao     = cw[CW_AO];
  assign eo     = cw[CW_EO];
  assign su     = cw[CW_SU];
  assign bi     = cw[CW_BI];
  assign oi     = cw[CW_OI];
  assign ce     = cw[CW_CE];
  assign co     = cw[CW_CO];
  assign j      = cw[CW_J];
  assign fi     = cw[CW_FI];
  assign tstate = ts;

endmodule

// File: tb/tb_sap_controller.sv
// Directed self-checking bench for sap_controller; honours SAP_COND_JUMP_EN.
module tb_sap_controller;

  localparam logic [15:0] B_HLT = 16'h8000;
  localparam logic [15:0] B_MI  = 16'h4000;
  localparam logic [15:0] B_RI  = 16'h2000;
  localparam logic [15:0] B_RO  = 16'h1000;
  localparam logic [15:0] B_IO  = 16'h0800;
  localparam logic [15:0] B_II  = 16'h0400;
  localparam logic [15:0] B_AI  = 16'h0200;
  localparam logic [15:0] B_AO  = 16'h0100;
  localparam logic [15:0] B_EO  = 16'h0080;
  localparam logic [15:0] B_SU  = 16'h0040;
  localparam logic [15:0] B_BI  = 16'h0020;
  localparam logic [15:0] B_OI  = 16'h0010;
  localparam logic [15:0] B_CE  = 16'h0008;
  localparam logic [15:0] B_CO  = 16'h0004;
  localparam logic [15:0] B_J   = 16'h0002;
  localparam logic [15:0] B_FI  = 16'h0001;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] opcode = 4'h0;
  logic       carry_flag = 1'b0;
  logic       zero_flag = 1'b0;
  logic hlt, mi, ri, ro, io, ii, ai, ao, eo, su, bi, oi, ce, co, j, fi;
  logic [2:0] tstate;
  logic [15:0] word;

  int tests = 0;
  int fails = 0;

  assign word = {hlt, mi, ri, ro, io, ii, ai, ao, eo, su, bi, oi, ce, co, j, fi};

  always #5 clk = ~clk;

  sap_controller #(.OPCODE_W(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode),
    .carry_flag(carry_flag), .zero_flag(zero_flag),
    .hlt(hlt), .mi(mi), .ri(ri), .ro(ro), .io(io), .ii(ii), .ai(ai), .ao(ao),
    .eo(eo), .su(su), .bi(bi), .oi(oi), .ce(ce), .co(co), .j(j), .fi(fi),
    .tstate(tstate)
  );

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    opcode = 4'h0; carry_flag = 1'b0; zero_flag = 1'b0;
    do_reset();
    tests++;
    if (tstate !== 3'd0 || word !== (B_CO | B_MI)) begin
      fails++;
      $display("FAIL reset: tstate=%0d word=%h, required tstate=0 word=%h", tstate, word, B_CO | B_MI);
    end
    $display("[TB] reset: tstate=%0d word=%h", tstate, word);
  endtask

  task automatic test_lda();
    logic [15:0] exp_w [6];
    logic [2:0]  exp_t [6];
    exp_w = '{B_CO | B_MI, B_RO | B_II | B_CE, B_IO | B_MI, B_RO | B_AI, 16'h0000, B_CO | B_MI};
    exp_t = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
    opcode = 4'b0001;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      tests++;
      if (tstate !== exp_t[i] || word !== exp_w[i]) begin
        fails++;
        $display("FAIL lda_c%0d: tstate=%0d word=%h, required tstate=%0d word=%h",
                 i, tstate, word, exp_t[i], exp_w[i]);
      end
      $display("[TB] lda cycle %0d: tstate=%0d word=%h", i, tstate, word);
      step();
    end
  endtask

  task automatic test_sub();
    logic [15:0] exp_w [5];
    exp_w = '{B_CO | B_MI, B_RO | B_II | B_CE, B_IO | B_MI, B_RO | B_BI, B_EO | B_SU | B_AI | B_FI};
    opcode = 4'b0011;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (word !== exp_w[i]) begin
        fails++;
        $display("FAIL sub_t%0d: word=%h, required %h", i, word, exp_w[i]);
      end
      $display("[TB] sub T%0d: word=%h", i, word);
      step();
    end
  endtask

  // T2/T3/T4 words for the remaining unconditional opcodes, including unlisted ones.
  task automatic test_opcode_map();
    logic [3:0]  ops [7];
    logic [15:0] e2 [7];
    logic [15:0] e3 [7];
    logic [15:0] e4 [7];
    logic [15:0] got;
    ops = '{4'b0000, 4'b0010, 4'b0100, 4'b0101, 4'b0110, 4'b1110, 4'b1010};
    e2  = '{16'h0, B_IO | B_MI, B_IO | B_MI, B_IO | B_AI, B_IO | B_J, B_AO | B_OI, 16'h0};
    e3  = '{16'h0, B_RO | B_BI, B_AO | B_RI, 16'h0, 16'h0, 16'h0, 16'h0};
    e4  = '{16'h0, B_EO | B_AI | B_FI, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    for (int k = 0; k < 7; k++) begin
      opcode = ops[k];
      do_reset();
      step(); step();
      for (int t = 2; t < 6; t++) begin
        got = (t == 2) ? e2[k] : (t == 3) ? e3[k] : (t == 4) ? e4[k] : (B_CO | B_MI);
        tests++;
        if (word !== got) begin
          fails++;
          $display("FAIL map_op%b_t%0d: word=%h, required %h", ops[k], t, word, got);
        end
        $display("[TB] op %b slot %0d: tstate=%0d word=%h", ops[k], t, tstate, word);
        step();
      end
    end
  endtask

  task automatic test_cond_jump();
    logic [15:0] exp;
    for (int k = 0; k < 4; k++) begin
      opcode     = (k < 2) ? 4'b0111 : 4'b1000;
      carry_flag = (k < 2) ? (k == 0) : 1'b0;
      zero_flag  = (k >= 2) ? (k == 2) : 1'b0;
      do_reset();
      step(); step();
`ifdef SAP_COND_JUMP_EN
      exp = (k == 0 || k == 2) ? (B_IO | B_J) : 16'h0;
`else
      exp = 16'h0;
`endif
      tests++;
      if (word !== exp) begin
        fails++;
        $display("FAIL cjump_%0d: word=%h, required %h", k, word, exp);
      end
      $display("[TB] cond jump op=%b c=%b z=%b: word=%h", opcode, carry_flag, zero_flag, word);
      // Flags asserted outside T2 must not cause a jump
      step();
      carry_flag = 1'b1; zero_flag = 1'b1;
      #1;
      tests++;
      if (word !== 16'h0) begin
        fails++;
        $display("FAIL cjump_t3_%0d: word=%h, required 0000", k, word);
      end
    end
    carry_flag = 1'b0; zero_flag = 1'b0;
  endtask

  task automatic test_hlt();
    int bad = 0;
    opcode = 4'b1111;
    do_reset();
    step(); step();
    tests++;
    if (word !== B_HLT || tstate !== 3'd2) begin
      fails++;
      $display("FAIL hlt_t2: tstate=%0d word=%h, required tstate=2 word=%h", tstate, word, B_HLT);
    end
    $display("[TB] hlt T2: tstate=%0d word=%h", tstate, word);
    for (int i = 0; i < 20; i++) begin
      step();
      opcode = 4'($urandom_range(0, 15));
      #1;
      if (tstate !== 3'd3 || word !== B_HLT) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL hlt_hold: %0d bad cycles, last tstate=%0d word=%h, required tstate=3 word=%h",
               bad, tstate, word, B_HLT);
    end
    $display("[TB] halted 20 cycles: tstate=%0d word=%h", tstate, word);
    opcode = 4'b0001;
    do_reset();
    tests++;
    if (tstate !== 3'd0 || word !== (B_CO | B_MI)) begin
      fails++;
      $display("FAIL hlt_reset: tstate=%0d word=%h, required tstate=0 word=%h", tstate, word, B_CO | B_MI);
    end
    $display("[TB] reset after halt: tstate=%0d word=%h", tstate, word);
  endtask

  task automatic test_reset_mid();
    opcode = 4'b0010;
    do_reset();
    step(); step(); step();
    do_reset();
    tests++;
    if (tstate !== 3'd0 || word !== (B_CO | B_MI)) begin
      fails++;
      $display("FAIL reset_mid: tstate=%0d word=%h, required tstate=0 word=%h", tstate, word, B_CO | B_MI);
    end
    $display("[TB] reset mid-instruction: tstate=%0d word=%h", tstate, word);
  endtask

  task automatic test_random();
    int bus_bad = 0;
    int j_bad = 0;
    int t_bad = 0;
    int exp_t = 0;
    int drivers;
    opcode = 4'b0000;
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      opcode     = 4'($urandom_range(0, 14));
      carry_flag = 1'($urandom_range(0, 1));
      zero_flag  = 1'($urandom_range(0, 1));
      #1;
      drivers = int'(ro) + int'(io) + int'(ao) + int'(eo) + int'(co);
      if (drivers > 1) bus_bad++;
      if (j === 1'b1 && tstate !== 3'd2) j_bad++;
      if (tstate !== 3'(exp_t)) t_bad++;
      exp_t = (exp_t + 1) % 5;
      step();
    end
    tests++;
    if (bus_bad != 0) begin
      fails++;
      $display("FAIL rand_bus: %0d cycles with multiple drivers, required 0", bus_bad);
    end
    tests++;
    if (j_bad != 0) begin
      fails++;
      $display("FAIL rand_j: %0d cycles with j outside T2, required 0", j_bad);
    end
    tests++;
    if (t_bad != 0) begin
      fails++;
      $display("FAIL rand_tstate: %0d cycles with wrong tstate, required 0", t_bad);
    end
    $display("[TB] random 2000 cycles: bus_bad=%0d j_bad=%0d t_bad=%0d", bus_bad, j_bad, t_bad);
  endtask

  initial begin
    test_reset();
    test_lda();
    test_sub();
    test_opcode_map();
    test_cond_jump();
    test_hlt();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
